sequence_generator_serial: RTL and testbench
============================================

// Module: sequence_generator_serial
// PURPOSE
// - Serial pattern transmitter: the driving end of the serial data line watched by the
//   sequence detectors (e.g. the 1010 detector).
// - Accepts a parallel pattern plus length/repeat/gap controls through a valid/ready handshake.
// - Emits the pattern MSB-first, one bit per clk, with optional idle gaps between repetitions.
// - Provides stimulus for detector blocks and drives serial test lines in the design.
// PARAMETERS
// - DATA_W   8  maximum pattern length in bits
// - LEN_W    4  width of length field; must hold DATA_W
// - REP_W    4  width of repeat field
// - GAP_W    4  width of gap field
// PORTS
// - clk          in   1       single clock; all logic on rising edge
// - resetn       in   1       asynchronous, active-low reset
// - start_valid  in   1       request to transmit
// - start_ready  out  1       high only in IDLE (includes the done cycle)
// - pattern      in   DATA_W  bits [length-1:0] are sent, MSB (bit length-1) first
// - length       in   LEN_W   number of bits per repetition; 0 allowed; >DATA_W clamps to DATA_W
// - repeat_cnt   in   REP_W   extra repetitions (0 = send once; N = N+1 times)
// - gap          in   GAP_W   idle cycles between repetitions (none after the last one)
// - data         out  1       serial bit; registered; 0 whenever data_valid=0
// - data_valid   out  1       data carries a pattern bit this cycle
// - busy         out  1       state != IDLE
// - done         out  1       one-cycle pulse after the final bit of the final repetition
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE; data=0, data_valid=0, busy=0, done=0.
//   All counters and shadow registers clear. start_ready=1 once resetn=1.
// - Accept: the rising edge with start_valid & start_ready & resetn.
//   - pattern, clamped length, repeat_cnt and gap are captured into shadow registers.
//   - Input changes after acceptance are ignored.
// - Latency: the first bit, pattern[len-1], appears on data the cycle after accept with data_valid=1.
//   Each bit is held exactly one cycle.
// - FSM: IDLE -> SHIFT (on accept, len>0); IDLE -> IDLE with done=1 next cycle (on accept, len=0).
//   - SHIFT: bit index counts len-1..0. At index 0:
//     - reps remaining and gap>0 -> GAP;
//     - reps remaining and gap=0 -> SHIFT, index reloads to len-1, no idle cycle;
//     - no reps remaining -> IDLE with done=1.
//   - GAP: data=0, data_valid=0, busy=1 for exactly gap cycles, then SHIFT with index reloaded.
//   - The repetition counter decrements on each SHIFT reload.
// - done: asserted in the first IDLE cycle. start_ready=1 in that same cycle, so back-to-back
//   accepts are legal and the next first bit follows immediately; zero dead cycles besides done.
// - start_valid while busy: no effect (start_ready=0); the request must be held until accepted.
// - Reset mid-transfer: outputs drop to reset values asynchronously. No done pulse; the transfer is lost.
// - Length clamp: a length field value > DATA_W sends exactly DATA_W bits.
// - Total cycles accept->done = (R+1)*L + R*G + 1, for L=clamped length, R=repeat_cnt, G=gap (L>0).
// STRUCTURE
// - Shared package seq_pkg holds:
//   - the state encoding localparams (IDLE, SHIFT, GAP);
//   - DET_PATTERN_1010 = 4'b1010 and DET_PATTERN_LEN = 4, shared with the detector and its benches.
// - One sub-module, seq_down_counter (parameterised width; load/enable/zero flag).
//   It is instantiated three times: bit index, gap count, repeat count.
// - FSM plus output register in this module.
// TESTING
// 1. pattern=8'h0A, length=4, repeat=0, gap=0 -> data=1,0,1,0 in cycles 1-4 after accept,
//    done=1 in cycle 5. A sequence_detector_1010 on the line asserts sequence_detected.
// 2. pattern=8'h0A, length=4, repeat=2, gap=3 -> 1010,000(valid=0),1010,000,1010.
//    done at cycle 4+3+4+3+4+1 = 19.
// 3. length=0 -> data_valid stays 0, done=1 the cycle after accept.
//    length=12, pattern=8'hA5 -> 8 bits 10100101, then done.
// 4. start_valid held high while busy with a different pattern -> start_ready=0, stream unchanged.
//    The second request is accepted in the done cycle, and its first bit follows in the next cycle.
// 5. resetn=0 during bit 2 of a 4-bit send -> data/data_valid/busy go 0 immediately, no done pulse.
//    After release, a new accept works normally.
// 6. repeat=1, gap=0, pattern=8'h0A, length=4 -> 8 contiguous valid bits 10101010, done at cycle 9.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator and the detectors it drives.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_state_e;

  localparam logic [3:0] DET_PATTERN_1010 = 4'b1010;
  localparam logic [3:0] DET_PATTERN_LEN  = 4'd4;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with a zero flag; load has priority over enable.
module seq_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/sequence_generator_serial.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, with repeats and idle gaps.
module sequence_generator_serial #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned REP_W  = 4,
  parameter int unsigned GAP_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] pattern,
  input  logic [LEN_W-1:0]  length,
  input  logic [REP_W-1:0]  repeat_cnt,
  input  logic [GAP_W-1:0]  gap,
  output logic              data,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  import seq_pkg::*;

  seq_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_pattern;
  logic [LEN_W-1:0]  r_len;
  logic [GAP_W-1:0]  r_gap;
  logic              r_data, r_valid, r_done;
  logic              w_data_nxt, w_valid_nxt, w_done_nxt;

  logic              w_accept;
  logic [LEN_W-1:0]  w_len_in;

  logic [LEN_W-1:0]  w_idx, w_idx_load_val;
  logic              w_idx_zero, w_idx_load, w_idx_en;
  logic [REP_W-1:0]  w_rep_cnt;
  logic              w_rep_zero, w_rep_load, w_rep_en;
  logic [GAP_W-1:0]  w_gap_cnt;
  logic              w_gap_zero, w_gap_load, w_gap_en;
  logic              w_unused_cnt;

  function automatic logic bit_at(input logic [DATA_W-1:0] p, input logic [LEN_W-1:0] i);
    return |(p & ({{(DATA_W-1){1'b0}}, 1'b1} << i));
  endfunction

  assign w_accept = start_valid && start_ready;
  assign w_len_in = (length > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : length;

  seq_down_counter #(.W(LEN_W)) u_idx_cnt (
    .clk(clk), .resetn(resetn), .i_load(w_idx_load), .i_load_val(w_idx_load_val),
    .i_en(w_idx_en), .o_count(w_idx), .o_zero(w_idx_zero)
  );

  seq_down_counter #(.W(REP_W)) u_rep_cnt (
    .clk(clk), .resetn(resetn), .i_load(w_rep_load), .i_load_val(repeat_cnt),
    .i_en(w_rep_en), .o_count(w_rep_cnt), .o_zero(w_rep_zero)
  );

  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .resetn(resetn), .i_load(w_gap_load), .i_load_val(r_gap - 1'b1),
    .i_en(w_gap_en), .o_count(w_gap_cnt), .o_zero(w_gap_zero)
  );

  assign w_unused_cnt = ^{w_rep_cnt, w_gap_cnt};

  // Next data bit is computed here and registered, so the first bit appears the cycle after accept.
  always_comb begin
    w_state_nxt    = r_state;
    w_data_nxt     = 1'b0;
    w_valid_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_idx_load     = 1'b0;
    w_idx_load_val = r_len - 1'b1;
    w_idx_en       = 1'b0;
    w_rep_load     = 1'b0;
    w_rep_en       = 1'b0;
    w_gap_load     = 1'b0;
    w_gap_en       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_rep_load = 1'b1;
          if (w_len_in == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt    = SHIFT;
            w_idx_load     = 1'b1;
            w_idx_load_val = w_len_in - 1'b1;
            w_valid_nxt    = 1'b1;
            w_data_nxt     = bit_at(pattern, w_len_in - 1'b1);
          end
        end
      end
      SHIFT: begin
        if (!w_idx_zero) begin
          w_idx_en    = 1'b1;
          w_valid_nxt = 1'b1;
          w_data_nxt  = bit_at(r_pattern, w_idx - 1'b1);
        end else if (!w_rep_zero) begin
          if (r_gap != '0) begin
            w_state_nxt = GAP;
            w_gap_load  = 1'b1;
          end else begin
            w_idx_load  = 1'b1;
            w_rep_en    = 1'b1;
            w_valid_nxt = 1'b1;
            w_data_nxt  = bit_at(r_pattern, r_len - 1'b1);
          end
        end else begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      GAP: begin
        if (w_gap_zero) begin
          w_state_nxt = SHIFT;
          w_idx_load  = 1'b1;
          w_rep_en    = 1'b1;
          w_valid_nxt = 1'b1;
          w_data_nxt  = bit_at(r_pattern, r_len - 1'b1);
        end else begin
          w_gap_en = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_data    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_pattern <= '0;
      r_len     <= '0;
      r_gap     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_pattern <= pattern;
        r_len     <= w_len_in;
        r_gap     <= gap;
      end
    end
  end

  assign start_ready = resetn && (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign data        = r_data;
  assign data_valid  = r_valid;
  assign done        = r_done;

endmodule

// File: tb/tb_sequence_generator_serial.sv
// Directed bench for sequence_generator_serial with hand-computed serial streams.
module tb_sequence_generator_serial;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] pattern;
  logic [3:0] length;
  logic [3:0] repeat_cnt;
  logic [3:0] gap;
  logic       data;
  logic       data_valid;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequence_generator_serial #(
    .DATA_W(8), .LEN_W(4), .REP_W(4), .GAP_W(4)
  ) dut (
    .clk(clk), .resetn(resetn), .start_valid(start_valid), .start_ready(start_ready),
    .pattern(pattern), .length(length), .repeat_cnt(repeat_cnt), .gap(gap),
    .data(data), .data_valid(data_valid), .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle k after accept (1..n-1) must show ed/ev bit [n-1-k]; cycle n is the done cycle.
  task automatic run_vec(input string name, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input logic [3:0] g,
                         input logic [31:0] ed, input logic [31:0] ev, input int n,
                         input bit hold, input logic [7:0] p2, input logic [3:0] l2);
    pattern = p; length = l; repeat_cnt = r; gap = g; start_valid = 1'b1;
    check_eq({name, ":ready_at_accept"}, start_ready, 1);
    tick();
    if (hold) begin
      pattern = p2; length = l2; repeat_cnt = 4'd0; gap = 4'd0;
    end else begin
      start_valid = 1'b0; pattern = ~p; length = 4'hF; repeat_cnt = 4'hF; gap = 4'hF;
    end
    for (int k = 1; k < n; k++) begin
      check_eq($sformatf("%s:data_c%0d", name, k), data, ed[n-1-k]);
      check_eq($sformatf("%s:valid_c%0d", name, k), data_valid, ev[n-1-k]);
      check_eq($sformatf("%s:busy_c%0d", name, k), busy, 1);
      check_eq($sformatf("%s:done_c%0d", name, k), done, 0);
      check_eq($sformatf("%s:ready_c%0d", name, k), start_ready, 0);
      tick();
    end
    check_eq({name, ":done"}, done, 1);
    check_eq({name, ":done_valid"}, data_valid, 0);
    check_eq({name, ":done_data"}, data, 0);
    check_eq({name, ":done_busy"}, busy, 0);
    check_eq({name, ":done_ready"}, start_ready, 1);
  endtask

  initial begin
    resetn = 1'b0; start_valid = 1'b0;
    pattern = '0; length = '0; repeat_cnt = '0; gap = '0;
    #12;
    check_eq("rst:data", data, 0);
    check_eq("rst:valid", data_valid, 0);
    check_eq("rst:busy", busy, 0);
    check_eq("rst:done", done, 0);
    check_eq("rst:ready_low", start_ready, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check_eq("rst:ready", start_ready, 1);
    check_eq("rst:idle_valid", data_valid, 0);

    run_vec("t1", {4'h0, seq_pkg::DET_PATTERN_1010}, seq_pkg::DET_PATTERN_LEN, 4'd0, 4'd0,
            32'b1010, 32'b1111, 5, 1'b0, 8'h00, 4'd0);
    run_vec("t2", 8'h0A, 4'd4, 4'd2, 4'd3,
            32'b101000010100001010, 32'b111100011110001111, 19, 1'b0, 8'h00, 4'd0);
    run_vec("t3_len0", 8'hFF, 4'd0, 4'd0, 4'd0, 32'b0, 32'b0, 1, 1'b0, 8'h00, 4'd0);
    run_vec("t3_clamp", 8'hA5, 4'd12, 4'd0, 4'd0, 32'hA5, 32'hFF, 9, 1'b0, 8'h00, 4'd0);
    run_vec("t6", 8'h0A, 4'd4, 4'd1, 4'd0, 32'hAA, 32'hFF, 9, 1'b0, 8'h00, 4'd0);

    run_vec("t4_first", 8'h0A, 4'd4, 4'd0, 4'd0, 32'b1010, 32'b1111, 5, 1'b1, 8'h3C, 4'd4);
    run_vec("t4_second", 8'h3C, 4'd4, 4'd0, 4'd0, 32'b1100, 32'b1111, 5, 1'b0, 8'h00, 4'd0);

    tick();
    check_eq("idle:done_cleared", done, 0);

    pattern = 8'h0A; length = 4'd4; repeat_cnt = 4'd0; gap = 4'd0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    check_eq("t5:bit1", data, 1);
    tick();
    check_eq("t5:bit2", data, 0);
    check_eq("t5:bit2_valid", data_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("t5:rst_data", data, 0);
    check_eq("t5:rst_valid", data_valid, 0);
    check_eq("t5:rst_busy", busy, 0);
    check_eq("t5:rst_done", done, 0);
    tick();
    tick();
    check_eq("t5:rst_hold_done", done, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check_eq("t5:post_done", done, 0);
    check_eq("t5:post_busy", busy, 0);
    check_eq("t5:post_valid", data_valid, 0);
    run_vec("t5_again", 8'h0A, 4'd4, 4'd0, 4'd0, 32'b1010, 32'b1111, 5, 1'b0, 8'h00, 4'd0);

    tick();
    check_eq("end:done_cleared", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
